// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared APB types and constants for the APB initiator and target blocks.
//   apb_h2d_t          : requester-to-completer bundle (psel, penable, paddr,
//                        pwrite, pwdata, pstrb, pprot)
//   apb_d2h_t          : completer-to-requester bundle (pready, prdata, pslverr)
//   apb_slave_state_e  : completer-side state encoding
//   apb_master_state_e : requester-side state encoding
//   ApbAddrAlignMask   : clears the byte offset so paddr is word aligned
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned ApbAddrW = 32;
    localparam int unsigned ApbDataW = 32;
    localparam int unsigned ApbStrbW = ApbDataW / 8;

    localparam logic [ApbAddrW-1:0] ApbAddrAlignMask = {{(ApbAddrW-2){1'b1}}, 2'b00};

    typedef struct packed {
        logic                psel;
        logic                penable;
        logic [ApbAddrW-1:0] paddr;
        logic                pwrite;
        logic [ApbDataW-1:0] pwdata;
        logic [ApbStrbW-1:0] pstrb;
        logic [2:0]          pprot;
    } apb_h2d_t;

    typedef struct packed {
        logic                pready;
        logic [ApbDataW-1:0] prdata;
        logic                pslverr;
    } apb_d2h_t;

    typedef enum logic {
        SlvIdle,
        SlvAccess
    } apb_slave_state_e;

    // Requester-side phases, kept apart from the completer encoding so the
    // two sides can evolve independently.
    typedef enum logic [1:0] {
        MstIdle,
        MstSetup,
        MstAccess
    } apb_master_state_e;

endpackage

// File: rtl/apb_master_req.sv
// ---------------------------------------------------------------------------
// apb_master_req
// APB requester: turns a single-outstanding valid/ready request/response
// interface into APB SETUP/ACCESS transfers, with an optional ACCESS-phase
// timeout.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_write_i              1 = write, 0 = read
//   req_addr_i               byte address (word aligned onto paddr)
//   req_wdata_i/req_wstrb_i  write data and byte strobes
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o              read data (0 for writes and timeouts)
//   rsp_error_o              pslverr captured, or timeout
//   apb_o / apb_i            APB request / response bundles
// ---------------------------------------------------------------------------
module apb_master_req
    import apb_pkg::*;
#(
    parameter int unsigned AddrW         = 32,
    parameter int unsigned DataW         = 32,
    parameter int unsigned StrbW         = DataW / 8,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [AddrW-1:0] req_addr_i,
    input  logic [DataW-1:0] req_wdata_i,
    input  logic [StrbW-1:0] req_wstrb_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DataW-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output apb_h2d_t         apb_o,
    input  apb_d2h_t         apb_i
);

    // A disabled timeout still needs a legal (1-bit) counter width.
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] TimeoutLast =
        CntW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

    apb_master_state_e state_q, state_d;

    logic [ApbAddrW-1:0] paddr_q;
    logic                pwrite_q;
    logic [DataW-1:0]    pwdata_q;
    logic [StrbW-1:0]    pstrb_q;

    logic                rsp_valid_q;
    logic [DataW-1:0]    rsp_rdata_q;
    logic                rsp_error_q;

    logic [CntW-1:0]     cnt_q;

    logic [ApbAddrW-1:0] addr_ext;
    logic                req_hs;
    logic                rsp_hs;
    logic                done_ok;
    logic                done_timeout;
    logic                timeout_hit;

    // Fit the request address onto the APB address bus.
    if (AddrW >= ApbAddrW) begin : g_addr_trunc
        assign addr_ext = req_addr_i[ApbAddrW-1:0];
    end else begin : g_addr_ext
        assign addr_ext = {{(ApbAddrW-AddrW){1'b0}}, req_addr_i};
    end

    // Ready depends only on registered state, so no input reaches it.
    assign req_ready_o = (state_q == MstIdle) && !rsp_valid_q;
    assign rsp_hs      = rsp_valid_q && rsp_ready_i;
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MstIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the per-cycle capture strobes. A pready in the last
    // allowed cycle takes priority over the timeout abort.
    always_comb begin
        state_d      = state_q;
        req_hs       = 1'b0;
        done_ok      = 1'b0;
        done_timeout = 1'b0;
        unique case (state_q)
            MstIdle: begin
                if (req_valid_i && req_ready_o) begin
                    req_hs  = 1'b1;
                    state_d = MstSetup;
                end
            end
            MstSetup: begin
                state_d = MstAccess;
            end
            MstAccess: begin
                if (apb_i.pready) begin
                    done_ok = 1'b1;
                    state_d = MstIdle;
                end else if (timeout_hit) begin
                    done_timeout = 1'b1;
                    state_d      = MstIdle;
                end
            end
            default: begin
                state_d = MstIdle;
            end
        endcase
    end

    // Transfer attributes are latched at acceptance and held until the next
    // acceptance, which keeps them stable through SETUP and every ACCESS cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (req_hs) begin
            paddr_q  <= addr_ext & ApbAddrAlignMask;
            pwrite_q <= req_write_i;
            pwdata_q <= req_write_i ? req_wdata_i : '0;
            pstrb_q  <= req_write_i ? req_wstrb_i : '0;
        end
    end

    // ACCESS wait-state counter; restarts for every new transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (req_hs) begin
            cnt_q <= '0;
        end else if ((state_q == MstAccess) && !apb_i.pready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Single response register; holds until the consumer takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else if (done_ok) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : apb_i.prdata;
            rsp_error_q <= apb_i.pslverr;
        end else if (done_timeout) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
        end else if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;

    // psel/penable come straight from the state register, so an async reset
    // drops them immediately.
    always_comb begin
        apb_o         = '0;
        apb_o.psel    = (state_q != MstIdle);
        apb_o.penable = (state_q == MstAccess);
        apb_o.paddr   = paddr_q;
        apb_o.pwrite  = pwrite_q;
        apb_o.pwdata  = pwdata_q;
        apb_o.pstrb   = pstrb_q;
    end

endmodule

// File: tb/tb_apb_master_req.sv
// ---------------------------------------------------------------------------
// tb_apb_master_req
// Scoreboard bench for apb_master_req: stimulus pushes the expected response
// and transfer shape, a monitor pops and compares on each response handshake,
// and a simple APB completer model supplies wait states, data and errors.
// ---------------------------------------------------------------------------
module tb_apb_master_req;
    import apb_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        int          access;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    apb_h2d_t    apb_o;
    apb_d2h_t    apb_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    exp_t sb_q[$];

    // Completer model controls.
    int          slv_wait = 0;
    logic        slv_hang = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;

    apb_master_req #(
        .AddrW(32),
        .DataW(32),
        .StrbW(4),
        .TimeoutCycles(8)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_write_i(req_write),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error),
        .apb_o(apb_o),
        .apb_i(apb_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void flag_fail(string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: bound expired", name);
    endfunction

    function automatic exp_t mk_exp(logic [31:0] rdata, logic err, logic [31:0] paddr,
                                     logic pwrite, logic [31:0] pwdata, logic [3:0] pstrb,
                                     int access);
        exp_t e;
        e.rdata  = rdata;
        e.err    = err;
        e.paddr  = paddr;
        e.pwrite = pwrite;
        e.pwdata = pwdata;
        e.pstrb  = pstrb;
        e.access = access;
        return e;
    endfunction

    // Completer model: decides pready for each ACCESS cycle just after the
    // edge that entered it; outside the ready cycle it drives junk that the
    // requester must ignore.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        apb_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (apb_o.psel && apb_o.penable) begin
                apb_i.pready = !slv_hang && (acc_cnt == slv_wait);
                apb_i.prdata = apb_i.pready ? slv_rdata : 32'hDEAD_0000;
                apb_i.pslverr = apb_i.pready ? slv_err : 1'b1;
                acc_cnt++;
            end else begin
                apb_i.pready  = 1'b0;
                apb_i.prdata  = 32'hDEAD_0000;
                apb_i.pslverr = 1'b1;
                acc_cnt = 0;
            end
        end
    end

    // Monitor: tracks the APB shape of the current transfer and checks it,
    // with the response, against the scoreboard on each response handshake.
    int          accept_cyc = 0;
    int          first_valid = 0;
    int          setup_n = 0;
    int          access_n = 0;
    logic        proto_ok = 1'b1;
    logic        in_rsp = 1'b0;
    logic [31:0] s_paddr, s_pwdata, h_rdata;
    logic        s_pwrite, h_err;
    logic [3:0]  s_pstrb;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            setup_n  = 0;
            access_n = 0;
            proto_ok = 1'b1;
            in_rsp   = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                accept_cyc = cyc;
                setup_n    = 0;
                access_n   = 0;
                proto_ok   = 1'b1;
            end
            if (apb_o.psel) begin
                if (!apb_o.penable) begin
                    setup_n++;
                    s_paddr  = apb_o.paddr;
                    s_pwrite = apb_o.pwrite;
                    s_pwdata = apb_o.pwdata;
                    s_pstrb  = apb_o.pstrb;
                end else begin
                    access_n++;
                    if (setup_n == 0 || apb_o.paddr !== s_paddr || apb_o.pwrite !== s_pwrite ||
                        apb_o.pwdata !== s_pwdata || apb_o.pstrb !== s_pstrb)
                        proto_ok = 1'b0;
                end
            end else if (apb_o.penable) begin
                proto_ok = 1'b0;
            end
            if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp      = 1'b1;
                    first_valid = cyc;
                    h_rdata     = rsp_rdata;
                    h_err       = rsp_error;
                end else begin
                    check_output("rsp_hold_stable", {rsp_error, rsp_rdata}, {h_err, h_rdata});
                    check_output("req_ready_low_while_rsp", req_ready, 0);
                end
                if (rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        flag_fail("unexpected_rsp");
                    end else begin
                        mon_e = sb_q.pop_front();
                        check_output("rsp_rdata", rsp_rdata, mon_e.rdata);
                        check_output("rsp_error", rsp_error, mon_e.err);
                        check_output("paddr", s_paddr, mon_e.paddr);
                        check_output("pwrite", s_pwrite, mon_e.pwrite);
                        check_output("pwdata", s_pwdata, mon_e.pwdata);
                        check_output("pstrb", s_pstrb, mon_e.pstrb);
                        check_output("setup_cycles", setup_n, 1);
                        check_output("access_cycles", access_n, mon_e.access);
                        check_output("apb_hold_stable", proto_ok, 1);
                        check_output("rsp_latency", first_valid - accept_cyc, 2 + mon_e.access);
                    end
                    in_rsp      = 1'b0;
                    last_hs_cyc = cyc;
                    done_cnt++;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, input exp_t e, output int acc_cyc);
        int budget;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        sb_q.push_back(e);
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) flag_fail("req_accept");
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int budget;
        budget = 0;
        while (done_cnt < target && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (done_cnt < target) flag_fail("rsp_wait");
    endtask

    initial begin
        int a1, a2, budget;
        logic seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_output("reset_req_ready", req_ready, 1);
        check_output("reset_psel_penable", {apb_o.psel, apb_o.penable}, 0);
        check_output("reset_apb_fields", {apb_o.paddr, apb_o.pwdata, apb_o.pstrb, apb_o.pwrite, apb_o.pprot}, 0);
        check_output("reset_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);

        // Zero-wait write; unaligned address, slave data must be dropped
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hFFFF_FFFF;
        apply_stimulus(1'b1, 32'h13, 32'hDEAD_BEEF, 4'hF,
                       mk_exp(32'h0, 1'b0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1), a1);
        wait_done(1);

        // Read with 3 wait states; wdata/strb forced to 0
        slv_wait = 3; slv_rdata = 32'hA5A5_0001;
        apply_stimulus(1'b0, 32'h04, 32'h1111_1111, 4'hF,
                       mk_exp(32'hA5A5_0001, 1'b0, 32'h04, 1'b0, 32'h0, 4'h0, 4), a1);
        wait_done(2);

        // Read with pslverr
        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'hCAFE_0008;
        apply_stimulus(1'b0, 32'h0A, 32'h0, 4'h0,
                       mk_exp(32'hCAFE_0008, 1'b1, 32'h08, 1'b0, 32'h0, 4'h0, 1), a1);
        wait_done(3);
        slv_err = 1'b0;

        // Back-to-back writes: 4-cycle request spacing
        slv_rdata = 32'h0;
        apply_stimulus(1'b1, 32'h100, 32'h1, 4'h3,
                       mk_exp(32'h0, 1'b0, 32'h100, 1'b1, 32'h1, 4'h3, 1), a1);
        apply_stimulus(1'b1, 32'h107, 32'h2, 4'hC,
                       mk_exp(32'h0, 1'b0, 32'h104, 1'b1, 32'h2, 4'hC, 1), a2);
        check_output("req_spacing", a2 - a1, 4);
        wait_done(5);

        // Timeout: pready never comes
        slv_hang = 1'b1;
        apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0,
                       mk_exp(32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 8), a1);
        wait_done(6);
        slv_hang = 1'b0;

        // pready on the last allowed ACCESS cycle wins
        slv_wait = 7; slv_rdata = 32'h0BAD_F00D;
        apply_stimulus(1'b0, 32'h44, 32'h0, 4'h0,
                       mk_exp(32'h0BAD_F00D, 1'b0, 32'h44, 1'b0, 32'h0, 4'h0, 8), a1);
        wait_done(7);

        // Response back-pressure with a pending request
        slv_wait = 0; slv_rdata = 32'h5555_AAAA; rsp_ready = 1'b0;
        apply_stimulus(1'b0, 32'h50, 32'h0, 4'h0,
                       mk_exp(32'h5555_AAAA, 1'b0, 32'h50, 1'b0, 32'h0, 4'h0, 1), a1);
        fork
            apply_stimulus(1'b1, 32'h60, 32'h77, 4'hF,
                           mk_exp(32'h0, 1'b0, 32'h60, 1'b1, 32'h77, 4'hF, 1), a2);
            begin
                budget = 0;
                while (!rsp_valid && budget < 50) begin
                    @(negedge clk);
                    budget++;
                end
                if (!rsp_valid) flag_fail("rsp_valid_wait");
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        check_output("accept_after_rsp_hs", a2 - last_hs_cyc, 1);
        wait_done(9);

        // Reset during the ACCESS phase of a write
        slv_hang = 1'b1;
        apply_stimulus(1'b1, 32'h80, 32'h1234_5678, 4'hF,
                       mk_exp(32'h0, 1'b0, 32'h80, 1'b1, 32'h1234_5678, 4'hF, 1), a1);
        budget = 0;
        while (!(apb_o.psel && apb_o.penable) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!(apb_o.psel && apb_o.penable)) flag_fail("access_wait");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("rst_psel_penable", {apb_o.psel, apb_o.penable}, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        sb_q.delete();
        slv_hang = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_req_ready", req_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check_output("no_stale_rsp", seen, 0);

        // Normal traffic after reset
        slv_wait = 1; slv_rdata = 32'h600D_CAFE;
        apply_stimulus(1'b0, 32'h1FC, 32'h0, 4'h0,
                       mk_exp(32'h600D_CAFE, 1'b0, 32'h1FC, 1'b0, 32'h0, 4'h0, 2), a1);
        wait_done(10);

        check_output("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
